alu_cmd_seq: RTL and testbench
==============================

Name: alu_cmd_seq

Overview:
- Command sequencer directly upstream of the combinational `alu`.
- Buffers {op, a, b} commands in a small FIFO and issues one per cycle to the ALU.
- Registers the ALU result {y, flg} into a valid/ready output stage.
- Adds opcode 4'b1000 (unsigned multiply), executed as an iterative shift-add over N cycles, since the ALU has no multiplier.

Parameters:
- N, 8, operand width; must match the ALU's N.
- DEPTH, 4, command FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  command valid
- in_ready  output  1  command accepted when in_valid && in_ready
- in_op  input  4  opcode
- in_a  input  N  operand A
- in_b  input  N  operand B
- alu_op  output  4  to ALU op
- alu_a  output  N  to ALU a
- alu_b  output  N  to ALU b
- alu_y  input  N  from ALU y
- alu_flg  input  1  from ALU flg
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_op  output  4  opcode of the result
- out_y  output  N  result; low half of the product for MUL
- out_hi  output  N  product high half for MUL; 0 otherwise
- out_flg  output  1  alu_flg; for MUL, (out_hi != 0)
- busy  output  1  state != IDLE, or FIFO not empty, or out_valid

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO emptied, pointers and count = 0, state = IDLE.
  - out_valid, out_op, out_y, out_hi, out_flg = 0.
  - Multiply registers = 0.
  - A reset during MUL or HOLD aborts the operation; no partial result is ever presented.
- FIFO:
  - in_ready = (count != DEPTH). No pass-through, so when full a push is refused even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle keep count unchanged.
  - Pointers wrap modulo DEPTH.
- ALU drive: alu_op/alu_a/alu_b = FIFO head entry, combinationally; all zeros when the FIFO is empty.
- Output stage:
  - out_free = !out_valid || out_ready.
  - Loading a new result while out_free and out_ready are both high replaces the old result in the same edge, giving full throughput.
  - While out_valid && !out_ready, out_* are held stable.
- FSM states: IDLE, MUL, HOLD.
  - IDLE, FIFO non-empty, out_free, head op != 4'b1000:
    - Pop the head.
    - Capture out_y = alu_y, out_flg = alu_flg, out_hi = 0, out_op = head op.
    - out_valid = 1 after the edge; stay in IDLE.
    - Throughput is 1 per cycle. Latency is one cycle from the accepting edge to out_valid, when the FIFO was empty.
  - IDLE, FIFO non-empty, head op == 4'b1000: pop regardless of out_free.
    - Load mcand = {N'b0, a}, mplier = b, acc = 0, cnt = 0; go to MUL.
  - MUL, each cycle:
    - acc += mplier[0] ? mcand : 0; mcand <<= 1; mplier >>= 1; cnt++.
    - On the iteration where cnt == N-1, if out_free: write out_hi/out_y = acc (including this iteration's add), out_flg = (hi != 0), out_op = 4'b1000, then go to IDLE.
    - Otherwise store the final acc and go to HOLD.
    - Product is unsigned, 2N bits, no truncation.
  - HOLD: when out_free, write the stored product to the output as above, then go to IDLE.
  - MUL and HOLD issue no commands; the FIFO keeps accepting pushes until full.
- Opcodes 4'b1001–4'b1111: issued to the ALU like any non-MUL op; the result is whatever the ALU returns.
- Ordering: results leave in strict command order.
- MUL timing: pop edge k → out_valid after edge k+N, when out_free.

Test Plan:
- Single op, N=8: push op=0001, a=8'h05, b=8'h05, out_ready=1 → out_valid one cycle after acceptance, out_y=8'h00, out_flg=alu_flg, out_op=0001, busy falls the next cycle.
- Throughput: push 8 back-to-back ops (op=0101, a=8'h01, b=0..7) with out_ready=1 → in_ready stays 1; out_y = 01,02,04,…,80 on consecutive cycles, in order.
- Backpressure, out_ready=0: push until in_ready=0 → exactly DEPTH+1=5 accepted; outputs held stable; raise out_ready → all 5 delivered in order with no loss or duplication.
- Multiply: op=1000, a=8'hFF, b=8'hFF, out_ready=1 → out_valid exactly N=8 cycles after the pop edge, out_hi=8'hFE, out_y=8'h01, out_flg=1. Also 8'h03×8'h04 → out_hi=0, out_y=8'h0C, out_flg=0.
- MUL into a blocked output: hold out_ready=0 with a prior result pending, issue MUL 8'h10×8'h10 → FSM enters HOLD; after out_ready=1 the prior result is delivered, then out_hi=8'h01, out_y=8'h00.
- Reset mid-MUL: deassert rst_n 3 cycles into a MUL with 2 commands queued → out_valid=0 and in_ready=1 immediately (asynchronously), busy=0; after release, no stale result ever appears.

Source files
------------

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: queues {op,a,b} commands and issues them one at a time to an external
//   combinational ALU. It registers {y,flg} into a valid/ready output stage. Opcode 1000
//   is an unsigned multiply, done locally as an N-cycle shift-add.
// Latency: with an empty FIFO, out_valid rises 1 cycle after the accepting edge.
//   For MUL, out_valid rises N cycles after the pop edge.
// Backpressure: when out_ready is low, ALU ops wait at the FIFO head and a finished MUL
//   parks in HOLD. in_ready drops only when the FIFO is full.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready/in_op/in_a/in_b command input
//   alu_op/alu_a/alu_b -> alu_y/alu_flg  FIFO head to ALU, result back
//   out_valid/out_ready/out_op/out_y/out_hi/out_flg  registered result
//   busy                              anything in flight
module alu_cmd_seq #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_y,
  input  logic         alu_flg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_op,
  output logic [N-1:0] out_y,
  output logic [N-1:0] out_hi,
  output logic         out_flg,
  output logic         busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef struct packed {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  cmd_t          head;
  logic          empty, push, pop;

  state_t        state, state_nxt;
  logic [2*N-1:0] mcand, acc, mul_sum, prod;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          out_free, load_alu, load_mul, mul_start, mul_last;

  // FIFO. A full FIFO refuses a push even if a pop happens in the same cycle.
  assign empty    = (count == '0);
  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op, in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // The ALU sees the head entry. It sees zeros when the FIFO is empty.
  assign alu_op = empty ? '0 : head.op;
  assign alu_a  = empty ? '0 : head.a;
  assign alu_b  = empty ? '0 : head.b;

  assign out_free = !out_valid || out_ready;
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(N-1));
  // In MUL the result includes the current iteration's add. HOLD already stored it in acc.
  assign prod     = (state == HOLD) ? acc : mul_sum;
  assign busy     = (state != IDLE) || !empty || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head.op == OP_MUL) begin
            // The multiply holds its operands locally, so it can leave the FIFO
            // even while the output stage is blocked.
            pop       = 1'b1;
            mul_start = 1'b1;
            state_nxt = MUL;
          end else if (out_free) begin
            pop      = 1'b1;
            load_alu = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_last) begin
          if (out_free) begin
            load_mul  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          load_mul  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath: mcand moves left and mplier moves right, one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (mul_start) begin
      mcand  <= {{N{1'b0}}, head.a};
      mplier <= head.b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= mul_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // Output stage. A load while out_ready is high replaces the result being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_y     <= '0;
      out_hi    <= '0;
      out_flg   <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      out_op    <= head.op;
      out_y     <= alu_y;
      out_hi    <= '0;
      out_flg   <= alu_flg;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      out_op    <= OP_MUL;
      out_y     <= prod[N-1:0];
      out_hi    <= prod[2*N-1:N];
      out_flg   <= |prod[2*N-1:N];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: scoreboard bench for alu_cmd_seq with a behavioural ALU attached.
// Accepted commands push their expected result. A monitor pops it on each output handshake.
// Inputs change 1 time unit after posedge. Handshakes and outputs are sampled on negedge.
module tb_alu_cmd_seq;
  localparam int N     = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] y;
    logic [7:0] hi;
    logic       flg;
  } res_t;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [3:0] in_op;
  logic [7:0] in_a, in_b;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_flg;
  logic       out_valid, out_ready;
  logic [3:0] out_op;
  logic [7:0] out_y, out_hi;
  logic       out_flg, busy;

  res_t sb[$];
  res_t last, held;
  bit   hold_vld;
  int   checks, errors, nout;

  alu_cmd_seq #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_flg(alu_flg),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_y(out_y),
    .out_hi(out_hi), .out_flg(out_flg), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in ALU. It returns {flg, y}, and flg is set when y is zero.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    case (op)
      4'd0:    y = a + b;
      4'd1:    y = a - b;
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      4'd4:    y = a ^ b;
      4'd5:    y = a << b[2:0];
      4'd6:    y = a >> b[2:0];
      4'd7:    y = a;
      default: y = ~(a ^ b) + {4'b0, op};
    endcase
    return {(y == 8'd0), y};
  endfunction

  always_comb {alu_flg, alu_y} = alu_f(alu_op, alu_a, alu_b);

  // Expected result of one command.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    res_t       r;
    logic [15:0] p;
    logic [8:0] f;
    if (op == 4'b1000) begin
      p     = {8'd0, a} * {8'd0, b};
      r.op  = op;
      r.y   = p[7:0];
      r.hi  = p[15:8];
      r.flg = (p[15:8] != 8'd0);
    end else begin
      f     = alu_f(op, a, b);
      r.op  = op;
      r.y   = f[7:0];
      r.hi  = 8'd0;
      r.flg = f[8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor and scoreboard.
  initial begin
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld && out_valid)
          chk("hold_stable", {out_op, out_y, out_hi, out_flg}, held);
        hold_vld = out_valid && !out_ready;
        held     = {out_op, out_y, out_hi, out_flg};
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", {out_op, out_y, out_hi, out_flg});
          end else begin
            chk("result", {out_op, out_y, out_hi, out_flg}, sb.pop_front());
            last = {out_op, out_y, out_hi, out_flg};
            nout++;
          end
        end
        if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b));
      end
    end
  end

  // This task is called 1 time unit after posedge. It returns 1 time unit after the acceptance edge.
  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_msg("push_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns the number of edges after the acceptance edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 60);
    if (!out_valid) fail_msg("wait_valid_timeout");
    lat = c - 1;
  endtask

  task automatic wait_outputs(input int target);
    int c = 0;
    while (nout < target && c < 1000) begin
      @(posedge clk);
      c++;
    end
    #1;
  endtask

  initial begin
    int lat, acc, nout0, c;
    checks = 0; errors = 0; nout = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_alu_drive", {alu_op, alu_a, alu_b}, 0);
    chk("rst_out_regs", {out_op, out_y, out_hi, out_flg}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op: 5-5.
    out_ready = 1'b1;
    push_cmd(4'b0001, 8'h05, 8'h05);
    wait_valid(lat);
    chk("single_latency", lat, 1);
    chk("single_y", out_y, 8'h00);
    chk("single_op", out_op, 4'b0001);
    chk("single_flg", out_flg, 1);
    @(negedge clk);
    chk("single_busy_fall", busy, 0);

    // Throughput: eight back-to-back shifts of 1.
    @(posedge clk); #1;
    nout0 = nout;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = 4'b0101; in_a = 8'h01; in_b = 8'(i);
      @(negedge clk);
      chk("tput_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("tput_consecutive", nout - nout0, 8);

    // Backpressure: fill with non-MUL commands while out_ready is low.
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_op = 4'($urandom_range(0, 15));
      if (in_op == 4'b1000) in_op = 4'b1001;
      in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", acc, DEPTH + 1);
    repeat (5) @(posedge clk); #1;
    chk("bp_out_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    nout0 = nout;
    out_ready = 1'b1;
    wait_outputs(nout0 + 5);
    chk("bp_drained", nout - nout0, 5);

    // Multiply 0xFF * 0xFF. Latency counts the pop edge plus N iterations.
    @(posedge clk); #1;
    push_cmd(4'b1000, 8'hFF, 8'hFF);
    wait_valid(lat);
    chk("mul_latency", lat, N + 1);
    chk("mul_ff_hi", out_hi, 8'hFE);
    chk("mul_ff_y", out_y, 8'h01);
    chk("mul_ff_flg", out_flg, 1);
    @(posedge clk); #1;
    push_cmd(4'b1000, 8'h03, 8'h04);
    wait_valid(lat);
    chk("mul_34_hi", out_hi, 8'h00);
    chk("mul_34_y", out_y, 8'h0C);
    chk("mul_34_flg", out_flg, 0);

    // MUL behind a blocked output.
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_cmd(4'b0000, 8'h12, 8'h34);
    push_cmd(4'b1000, 8'h10, 8'h10);
    repeat (15) @(posedge clk); #1;
    chk("hold_prior_valid", out_valid, 1);
    chk("hold_prior_y", {out_op, out_y}, {4'b0000, 8'h46});
    chk("hold_busy", busy, 1);
    nout0 = nout;
    out_ready = 1'b1;
    wait_outputs(nout0 + 2);
    chk("hold_count", nout - nout0, 2);
    chk("hold_mul_result", {last.op, last.hi, last.y}, {4'b1000, 8'h01, 8'h00});

    // Reset three iterations into a MUL, with two commands queued.
    @(posedge clk); #1;
    push_cmd(4'b1000, 8'h37, 8'h5A);
    push_cmd(4'b0010, 8'hF0, 8'h3C);
    push_cmd(4'b0011, 8'h0F, 8'h30);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    nout0 = nout;
    repeat (30) @(posedge clk); #1;
    chk("arst_no_stale", nout - nout0, 0);
    chk("arst_idle", busy, 0);

    // Randomized traffic with MULs mixed in and random backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = ($urandom_range(0, 4) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while ((sb.size() != 0 || busy) && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk("final_sb_empty", sb.size(), 0);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
